// File: rtl/pong_match_controller.sv
// Game-flow sequencer for the pong datapath: serve, play, miss freeze and game over.
// It gates the ball engine, re-serves the ball, and tracks score, lives and speed level.
module pong_match_controller #(
  parameter int LIVES          = 3,
  parameter int SERVE_FRAMES   = 60,
  parameter int MISS_FRAMES    = 90,
  parameter int HITS_PER_LEVEL = 8,
  parameter int MAX_LEVEL      = 3,
  parameter int SCORE_W        = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               start_btn,
  input  logic               paddle_hit,
  input  logic               ball_missed,
  output logic               ball_enable,
  output logic               ball_reload,
  output logic [1:0]         speed_level,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         lives,
  output logic [2:0]         state_out,
  output logic               game_over
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    MISS  = 3'd3,
    OVER  = 3'd4
  } state_t;

  state_t             state, nextState;
  logic               btnSync1, btnSync2, btnPrev, btnEdge;
  logic [7:0]         frameCnt, frameCntNext;
  logic [7:0]         hitCnt, hitCntNext;
  logic [SCORE_W-1:0] scoreNext;
  logic [2:0]         livesNext;
  logic [1:0]         levelNext;
  logic               reloadNext;

  // Two flops for metastability, a third remembers the previous level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btnSync1 <= 1'b0;
      btnSync2 <= 1'b0;
      btnPrev  <= 1'b0;
    end else begin
      btnSync1 <= start_btn;
      btnSync2 <= btnSync1;
      btnPrev  <= btnSync2;
    end
  end

  assign btnEdge = btnSync2 & ~btnPrev;

  always_comb begin
    nextState    = state;
    frameCntNext = frameCnt;
    hitCntNext   = hitCnt;
    scoreNext    = score;
    livesNext    = lives;
    levelNext    = speed_level;
    reloadNext   = 1'b0;
    case (state)
      IDLE: begin
        if (btnEdge) begin
          scoreNext    = '0;
          livesNext    = 3'(LIVES);
          levelNext    = 2'd0;
          hitCntNext   = 8'd0;
          frameCntNext = 8'd0;
          reloadNext   = 1'b1;
          nextState    = SERVE;
        end
      end
      SERVE: begin
        if (btnEdge || (frame_tick && frameCnt == 8'(SERVE_FRAMES - 1))) begin
          frameCntNext = 8'd0;
          nextState    = PLAY;
        end else if (frame_tick) begin
          frameCntNext = frameCnt + 8'd1;
        end
      end
      PLAY: begin
        // A miss in the same cycle as a hit discards the hit.
        if (ball_missed) begin
          if (lives != 3'd0) livesNext = lives - 3'd1;
          nextState = MISS;
        end else if (paddle_hit) begin
          if (score != '1) scoreNext = score + 1'b1;
          if (hitCnt == 8'(HITS_PER_LEVEL - 1)) begin
            hitCntNext = 8'd0;
            if (speed_level < 2'(MAX_LEVEL)) levelNext = speed_level + 2'd1;
          end else begin
            hitCntNext = hitCnt + 8'd1;
          end
        end
      end
      MISS: begin
        if (frame_tick && frameCnt == 8'(MISS_FRAMES - 1)) begin
          frameCntNext = 8'd0;
          if (lives == 3'd0) begin
            nextState = OVER;
          end else begin
            reloadNext = 1'b1;
            nextState  = SERVE;
          end
        end else if (frame_tick) begin
          frameCntNext = frameCnt + 8'd1;
        end
      end
      OVER: begin
        if (btnEdge) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      frameCnt    <= 8'd0;
      hitCnt      <= 8'd0;
      score       <= '0;
      lives       <= 3'(LIVES);
      speed_level <= 2'd0;
      ball_reload <= 1'b0;
      ball_enable <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      state       <= nextState;
      frameCnt    <= frameCntNext;
      hitCnt      <= hitCntNext;
      score       <= scoreNext;
      lives       <= livesNext;
      speed_level <= levelNext;
      ball_reload <= reloadNext;
      ball_enable <= (nextState == PLAY);
      game_over   <= (nextState == OVER);
    end
  end

  assign state_out = state;

endmodule
